// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer, two-wide allocate/retire.
// Optional head-exception squash is enabled by defining ROB_FLUSH_EN.
module reorder_buffer #(
    parameter int ROB_DEPTH     = 16,
    parameter int MACHINE_WIDTH = 2,
    parameter int CMT_PORTS     = 2,
    parameter int AW            = $clog2(ROB_DEPTH)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [MACHINE_WIDTH-1:0]    alloc_valid,
    input  logic [MACHINE_WIDTH*5-1:0]  alloc_dst,
    input  logic [MACHINE_WIDTH*32-1:0] alloc_pcplus8,
    input  logic [MACHINE_WIDTH-1:0]    alloc_exc,
    input  logic [MACHINE_WIDTH*5-1:0]  alloc_exccode,
    output logic                        alloc_ready,
    output logic [MACHINE_WIDTH*AW-1:0] alloc_addr,
    input  logic [CMT_PORTS-1:0]        cmt_valid,
    input  logic [CMT_PORTS*AW-1:0]     cmt_addr,
    input  logic [CMT_PORTS*32-1:0]     cmt_data,
    output logic [MACHINE_WIDTH-1:0]    retire_valid,
    output logic [MACHINE_WIDTH*5-1:0]  retire_dst,
    output logic [MACHINE_WIDTH*32-1:0] retire_data,
    output logic [MACHINE_WIDTH*32-1:0] retire_pcplus8,
    output logic [MACHINE_WIDTH-1:0]    retire_exc,
    output logic [MACHINE_WIDTH*5-1:0]  retire_exccode,
    output logic                        flush
);
    logic [ROB_DEPTH-1:0] valid_q, complete_q, exc_q;
    logic [4:0]           dst_q     [ROB_DEPTH];
    logic [4:0]           exccode_q [ROB_DEPTH];
    logic [31:0]          data_q    [ROB_DEPTH];
    logic [31:0]          pcplus8_q [ROB_DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [AW:0]   count_q, count_d, n_alloc, n_ret;
    logic          r0, r1, flush_w;
    logic [1:0]    alloc_fire;

    assign head1 = head_q + AW'(1);
    assign tail1 = tail_q + AW'(1);

    always_comb begin
        r0 = valid_q[head_q] & complete_q[head_q];
        r1 = r0 & valid_q[head1] & complete_q[head1];
`ifdef ROB_FLUSH_EN
        // An excepting head retires alone and squashes everything behind it.
        r1      = r1 & ~exc_q[head_q];
        flush_w = r0 & exc_q[head_q];
`else
        flush_w = 1'b0;
`endif
        alloc_ready   = (count_q <= (AW+1)'(ROB_DEPTH - MACHINE_WIDTH)) && !flush_w;
        alloc_fire[0] = alloc_ready & alloc_valid[0];
        alloc_fire[1] = alloc_ready & alloc_valid[0] & alloc_valid[1];
        n_alloc = (AW+1)'(alloc_fire[0]) + (AW+1)'(alloc_fire[1]);
        n_ret   = (AW+1)'(r0) + (AW+1)'(r1);
        if (flush_w) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + n_ret[AW-1:0];
            tail_d  = tail_q + n_alloc[AW-1:0];
            count_d = count_q + n_alloc - n_ret;
        end
    end

    assign alloc_addr     = {tail1, tail_q};
    assign retire_valid   = {r1, r0};
    assign retire_dst     = {dst_q[head1], dst_q[head_q]};
    assign retire_data    = {data_q[head1], data_q[head_q]};
    assign retire_pcplus8 = {pcplus8_q[head1], pcplus8_q[head_q]};
    assign retire_exc     = {exc_q[head1], exc_q[head_q]};
    assign retire_exccode = {exccode_q[head1], exccode_q[head_q]};
    assign flush          = flush_w;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            complete_q <= '0;
            exc_q      <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dst_q[i]     <= '0;
                exccode_q[i] <= '0;
                data_q[i]    <= '0;
                pcplus8_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush_w) begin
                valid_q    <= '0;
                complete_q <= '0;
            end else begin
                // Later ports overwrite earlier ones on an address collision.
                for (int j = 0; j < CMT_PORTS; j++) begin
                    if (cmt_valid[j] && valid_q[cmt_addr[j*AW +: AW]]) begin
                        complete_q[cmt_addr[j*AW +: AW]] <= 1'b1;
                        data_q[cmt_addr[j*AW +: AW]]     <= cmt_data[j*32 +: 32];
                    end
                end
                if (r0) begin
                    valid_q[head_q]    <= 1'b0;
                    complete_q[head_q] <= 1'b0;
                end
                if (r1) begin
                    valid_q[head1]    <= 1'b0;
                    complete_q[head1] <= 1'b0;
                end
                if (alloc_fire[0]) begin
                    valid_q[tail_q]    <= 1'b1;
                    complete_q[tail_q] <= alloc_exc[0];
                    exc_q[tail_q]      <= alloc_exc[0];
                    dst_q[tail_q]      <= alloc_dst[4:0];
                    exccode_q[tail_q]  <= alloc_exccode[4:0];
                    pcplus8_q[tail_q]  <= alloc_pcplus8[31:0];
                    data_q[tail_q]     <= '0;
                end
                if (alloc_fire[1]) begin
                    valid_q[tail1]    <= 1'b1;
                    complete_q[tail1] <= alloc_exc[1];
                    exc_q[tail1]      <= alloc_exc[1];
                    dst_q[tail1]      <= alloc_dst[9:5];
                    exccode_q[tail1]  <= alloc_exccode[9:5];
                    pcplus8_q[tail1]  <= alloc_pcplus8[63:32];
                    data_q[tail1]     <= '0;
                end
            end
        end
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between the renaming stage (allocation) and the retire stage (architectural register file write).
- Renaming allocates up to MACHINE_WIDTH entries per cycle and receives their ROB indices.
- Commit/writeback marks entries complete and stores their results.
- Up to MACHINE_WIDTH oldest complete entries leave in program order each cycle and drive the ARF write ports.

Parameters:
ROB_DEPTH, 16, entry count; power of two, >= 4
MACHINE_WIDTH, 2, allocate/retire slots per cycle; fixed at 2 for this revision
CMT_PORTS, 2, completion write ports (equal to ALU_NUM)
AW, $clog2(ROB_DEPTH), ROB index width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
alloc_valid  in  MACHINE_WIDTH  per-slot allocate request; slot1 only when slot0 is set
alloc_dst  in  MACHINE_WIDTH*5  architectural destination (0 = no write)
alloc_pcplus8  in  MACHINE_WIDTH*32  pc+8 of the instruction
alloc_exc  in  MACHINE_WIDTH  exception flag detected before issue
alloc_exccode  in  MACHINE_WIDTH*5  exception code
alloc_ready  out  1  at least MACHINE_WIDTH free entries
alloc_addr  out  MACHINE_WIDTH*AW  index assigned to each slot: tail, tail+1
cmt_valid  in  CMT_PORTS  completion write enable
cmt_addr  in  CMT_PORTS*AW  entry being completed
cmt_data  in  CMT_PORTS*32  result value
retire_valid  out  MACHINE_WIDTH  slot retires this cycle
retire_dst  out  MACHINE_WIDTH*5  ARF write address
retire_data  out  MACHINE_WIDTH*32  ARF write data
retire_pcplus8  out  MACHINE_WIDTH*32  pc+8 of the retiring instruction
retire_exc  out  MACHINE_WIDTH  exception flag
retire_exccode  out  MACHINE_WIDTH*5  exception code
flush  out  1  head exception retiring; pipeline must be squashed (ROB_FLUSH_EN only)

Behaviour:
- State per entry:
  - valid, complete, dst, data, pcplus8, exc, exccode.
  - head and tail: AW bits, wrap modulo ROB_DEPTH.
  - count: AW+1 bits.
- Reset (async, resetn low):
  - head = tail = count = 0; all valid and complete = 0.
  - Outputs: alloc_ready = 1, alloc_addr = {1,0}, retire_valid = 0, flush = 0.
  - Reset mid-operation discards every entry immediately.
- Allocation:
  - alloc_ready = (count <= ROB_DEPTH - MACHINE_WIDTH) && !flush.
  - The ready check uses the registered count; same-cycle retires give no bypass.
  - Allocation is all-or-nothing per cycle. When alloc_ready = 0, alloc_valid is ignored.
  - On the clock edge with alloc_ready = 1, each valid slot writes entry tail+i:
    - valid = 1, complete = alloc_exc[i] (excepting entries need no execution), data = 0.
  - tail advances by the number of valid slots. alloc_addr is combinational from tail.
- Completion:
  - On the clock edge, each cmt_valid[j] whose addressed entry is valid sets complete = 1 and data = cmt_data[j].
  - A write to an invalid entry is ignored.
  - Two ports to the same address: the higher port index wins.
  - Completing an entry in its allocation cycle is illegal and not handled.
  - Complete becomes visible to retire one cycle after the completion edge.
- Retire (combinational from registered entries; takes effect at the clock edge):
  - r0 = valid[head] && complete[head].
  - r1 = r0 && valid[head+1] && complete[head+1] && !(exc[head] under ROB_FLUSH_EN).
  - retire_* show entries head and head+1; retire_valid = {r1, r0}.
  - At the edge: head advances by r0+r1; retired entries clear valid and complete.
  - count_next = count + allocated - retired, so allocate and retire in the same cycle net out.
- Boundaries:
  - Full (count = ROB_DEPTH): alloc_ready = 0; retire proceeds normally.
  - Empty: retire_valid = 0.
  - Pointer wrap from ROB_DEPTH-1 to 0 is seamless; count distinguishes full from empty.
- No internal FSM beyond the flush behaviour below.

Optional Feature:
- Macro: ROB_FLUSH_EN.
- Defined:
  - flush = r0 && retire_exc[0], combinational.
  - Only the excepting head entry retires that cycle; slot1 is blocked.
  - alloc_ready is forced to 0.
  - At the edge: all entries clear valid/complete; head = tail = 0; count = 0.
  - Completions arriving in the flush cycle are discarded.
- Undefined:
  - The flush port is tied to 0.
  - Excepting entries retire like normal entries, with retire_exc/retire_exccode passed through.
  - No squash; exception handling is downstream.

Test Plan:
- Reset, then allocate 2 entries (dst 3 and 4), complete addr1 with 0xBBBB, then addr0 with 0xAAAA -> no retire until the addr0 completion is visible; then retire_valid = 2'b11, retire_data = {0xBBBB, 0xAAAA}, count back to 0.
- Allocate 2 per cycle for 8 cycles with no completion (DEPTH 16) -> alloc_ready = 0 when count = 16 and further requests are ignored; retire 2 -> alloc_ready = 1 the next cycle.
- Steady state with allocate 2 and retire 2 every cycle for 20 cycles -> count constant; alloc_addr wraps 14,15 -> 0,1; order preserved across the wrap.
- Completion ports 0 and 1 both write addr 5 with 0x11 and 0x22 -> entry 5 data = 0x22.
- ROB_FLUSH_EN: head entry allocated with alloc_exc = 1, exccode 0x0A, 3 entries behind it -> flush = 1 for one cycle with retire_valid = 2'b01; the next cycle count = 0, head = tail = 0, alloc_addr = {1,0}.
- Without ROB_FLUSH_EN, same stimulus -> flush stays 0; the excepting entry retires with retire_exc = 1 and younger complete entries continue retiring.
